id_ex_register: RTL and testbench
=================================

// Module: id_ex_register
// PURPOSE
//   ID/EX pipeline register of the 5-stage RISC-V core. It captures the ID-stage control bundle
//   (RegWrite/MemtoReg/MemRead/MemWrite/ALUOp/ALUSrc) plus operands, immediate, funct and register
//   addresses, and presents them to EX, forwarding and hazard logic one cycle later.
//   It supports downstream stall (hold), bubble insertion on flush with a deferred-flush latch,
//   and saturating bubble/stall counters for performance debug.
// PARAMETERS
//   XLEN   32  operand/immediate width
//   CNT_W  16  width of each saturating performance counter
// PORTS
//   clk_i          in   1      clock, rising edge
//   rst_i          in   1      asynchronous, active-low reset
//   stall_i        in   1      EX/MEM cannot accept; hold all outputs
//   flush_i        in   1      load a bubble instead of the ID instruction
//   valid_i        in   1      ID holds a real instruction (0 = NoOp bubble from Control)
//   RegWrite_i     in   1      control bundle from Control
//   MemtoReg_i     in   1
//   MemRead_i      in   1
//   MemWrite_i     in   1
//   ALUOp_i        in   2
//   ALUSrc_i       in   1
//   RS1data_i      in   XLEN   register-file read data 1
//   RS2data_i      in   XLEN   register-file read data 2
//   Imm_i          in   XLEN   sign-extended immediate
//   funct_i        in   10     {funct7, funct3}
//   RS1addr_i      in   5
//   RS2addr_i      in   5
//   RDaddr_i       in   5
//   *_o (same names and widths as the inputs above, RegWrite_o..RDaddr_o)  out  registered copies
//   valid_o        out  1      EX holds a real instruction
//   bubble_cnt_o   out  CNT_W  bubbles loaded since reset (saturating)
//   stall_cnt_o    out  CNT_W  stalled cycles since reset (saturating)
// BEHAVIOUR
//   Reset (rst_i=0, async): every output is 0 and flush_pend=0. This includes valid_o, all
//     control, data, address and counter outputs. Outputs stay 0 until the first edge with rst_i=1.
//   Latency: one cycle. Inputs sampled at rising edge n appear at outputs after edge n.
//   Per rising edge, priority is stall > flush > load:
//     stall_i=1: all pipeline outputs hold. stall_cnt +1 (saturates at 2^CNT_W-1).
//       flush_pend <= flush_pend | flush_i.
//     stall_i=0, (flush_i | flush_pend)=1: load a BUBBLE and clear flush_pend. bubble_cnt +1.
//     stall_i=0, no flush, valid_i=0: load a BUBBLE. bubble_cnt +1.
//     stall_i=0, no flush, valid_i=1: load all inputs. valid_o=1.
//   BUBBLE sets valid_o=0; RegWrite/MemtoReg/MemRead/MemWrite/ALUSrc=0; ALUOp=2'b00; RDaddr/RS1addr/
//     RS2addr=0, so forwarding never matches x0. Data/Imm/funct are zeroed.
//   Counters saturate and never wrap. Both may change on the same edge only via reset.
//   An ALU-type input with valid_i=0 is still a bubble; valid_i gates the load, not the opcode.
//   Reset mid-stall discards the held instruction and the pending flush.
// TESTING
//   Reset: rst_i=0 with inputs random -> all outputs 0. Release, then load valid R-type
//     (RegWrite=1, ALUOp=2'b10, RD=5) -> next cycle RegWrite_o=1, RDaddr_o=5, valid_o=1.
//   Stall hold: load I1 (RD=7), then stall_i=1 for 3 cycles while inputs change -> RDaddr_o=7
//     throughout; stall_cnt_o=3.
//   Deferred flush: stall_i=1 with flush_i=1 pulsed for one cycle, then stall_i=0 with flush_i=0
//     -> the edge after the stall loads a bubble (valid_o=0, RegWrite_o=0); bubble_cnt_o=1.
//   NoOp path: valid_i=0 with MemRead_i=1 -> MemRead_o=0, RDaddr_o=0, valid_o=0.
//   Saturation (CNT_W=4): 20 stalled cycles -> stall_cnt_o=15 and stays 15.
//   Async reset during stall -> outputs 0 immediately; first post-reset edge with flush_i=0
//     loads inputs normally.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures the ID control bundle, operands and register addresses for EX,
// with stall hold, bubble insertion (including a flush deferred across a stall) and perf counters.
module id_ex_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A flush seen while stalled is remembered and applied on the first unstalled edge.
  logic flush_pend;
  logic take_bubble;

  assign take_bubble = flush_i | flush_pend | ~valid_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o      <= 1'b0;
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      ALUOp_o      <= 2'b00;
      ALUSrc_o     <= 1'b0;
      RS1data_o    <= '0;
      RS2data_o    <= '0;
      Imm_o        <= '0;
      funct_o      <= '0;
      RS1addr_o    <= '0;
      RS2addr_o    <= '0;
      RDaddr_o     <= '0;
      flush_pend   <= 1'b0;
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else if (stall_i) begin
      flush_pend <= flush_pend | flush_i;
      if (stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end else if (take_bubble) begin
      // Zeroed register addresses keep forwarding from ever matching a bubble.
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUOp_o    <= 2'b00;
      ALUSrc_o   <= 1'b0;
      RS1data_o  <= '0;
      RS2data_o  <= '0;
      Imm_o      <= '0;
      funct_o    <= '0;
      RS1addr_o  <= '0;
      RS2addr_o  <= '0;
      RDaddr_o   <= '0;
      flush_pend <= 1'b0;
      if (bubble_cnt_o != CNT_MAX) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end else begin
      valid_o    <= 1'b1;
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      ALUOp_o    <= ALUOp_i;
      ALUSrc_o   <= ALUSrc_i;
      RS1data_o  <= RS1data_i;
      RS2data_o  <= RS2data_i;
      Imm_o      <= Imm_i;
      funct_o    <= funct_i;
      RS1addr_o  <= RS1addr_i;
      RS2addr_o  <= RS2addr_i;
      RDaddr_o   <= RDaddr_i;
      flush_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_id_ex_register;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } stage_t;

  logic clk = 1'b0;
  logic rst_i, stall_i, flush_i, valid_i;
  logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

  logic RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, valid_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic [15:0] bubble_cnt_o, stall_cnt_o;

  // Second instance with 4-bit counters to reach saturation quickly.
  logic s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUSrc_o, s_valid_o;
  logic [1:0]  s_ALUOp_o;
  logic [31:0] s_RS1data_o, s_RS2data_o, s_Imm_o;
  logic [9:0]  s_funct_o;
  logic [4:0]  s_RS1addr_o, s_RS2addr_o, s_RDaddr_o;
  logic [3:0]  s_bubble_cnt_o, s_stall_cnt_o;

  always #5 clk = ~clk;

  id_ex_register #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  id_ex_register #(.XLEN(32), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o), .MemRead_o(s_MemRead_o),
    .MemWrite_o(s_MemWrite_o), .ALUOp_o(s_ALUOp_o), .ALUSrc_o(s_ALUSrc_o),
    .RS1data_o(s_RS1data_o), .RS2data_o(s_RS2data_o), .Imm_o(s_Imm_o), .funct_o(s_funct_o),
    .RS1addr_o(s_RS1addr_o), .RS2addr_o(s_RS2addr_o), .RDaddr_o(s_RDaddr_o),
    .valid_o(s_valid_o), .bubble_cnt_o(s_bubble_cnt_o), .stall_cnt_o(s_stall_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  stage_t      exp_stage;
  int unsigned n_bubble, n_stall;
  bit          pend;
  bit          check_en = 1'b0;

  function automatic stage_t input_bundle();
    return '{valid: 1'b1, reg_write: RegWrite_i, mem_to_reg: MemtoReg_i, mem_read: MemRead_i,
             mem_write: MemWrite_i, alu_op: ALUOp_i, alu_src: ALUSrc_i, rs1_data: RS1data_i,
             rs2_data: RS2data_i, imm: Imm_i, funct: funct_i, rs1_addr: RS1addr_i,
             rs2_addr: RS2addr_i, rd_addr: RDaddr_i};
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int w);
    int unsigned lim = (32'd1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      exp_stage <= '0;
      n_bubble  <= 0;
      n_stall   <= 0;
      pend      <= 1'b0;
    end else if (stall_i) begin
      n_stall <= n_stall + 1;
      pend    <= pend | flush_i;
    end else if (flush_i || pend || !valid_i) begin
      exp_stage <= '0;
      n_bubble  <= n_bubble + 1;
      pend      <= 1'b0;
    end else begin
      exp_stage <= input_bundle();
      pend      <= 1'b0;
    end
  end

  function automatic stage_t dut_stage();
    return '{valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o,
             RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o};
  endfunction

  function automatic stage_t dut_s_stage();
    return '{s_valid_o, s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUOp_o,
             s_ALUSrc_o, s_RS1data_o, s_RS2data_o, s_Imm_o, s_funct_o, s_RS1addr_o,
             s_RS2addr_o, s_RDaddr_o};
  endfunction

  // Single compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("stage", 160'(dut_stage()), 160'(exp_stage));
      check("stage_s", 160'(dut_s_stage()), 160'(exp_stage));
      check("bubble_cnt", 160'(bubble_cnt_o), 160'(sat(n_bubble, 16)));
      check("stall_cnt", 160'(stall_cnt_o), 160'(sat(n_stall, 16)));
      check("bubble_cnt_s", 160'(s_bubble_cnt_o), 160'(sat(n_bubble, 4)));
      check("stall_cnt_s", 160'(s_stall_cnt_o), 160'(sat(n_stall, 4)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_payload();
    RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom); MemRead_i = 1'($urandom);
    MemWrite_i = 1'($urandom); ALUOp_i = 2'($urandom); ALUSrc_i = 1'($urandom);
    RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom; funct_i = 10'($urandom);
    RS1addr_i = 5'($urandom); RS2addr_i = 5'($urandom); RDaddr_i = 5'($urandom);
  endtask

  task automatic r_type(input logic [4:0] rd);
    rand_payload();
    RegWrite_i = 1'b1; MemtoReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALUOp_i = 2'b10; ALUSrc_i = 1'b0; RDaddr_i = rd; valid_i = 1'b1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_valid"}, 160'(valid_o), 160'(0));
    check({tag, "_regwrite"}, 160'(RegWrite_o), 160'(0));
    check({tag, "_rd"}, 160'(RDaddr_o), 160'(0));
    check({tag, "_rs1data"}, 160'(RS1data_o), 160'(0));
    check({tag, "_bcnt"}, 160'(bubble_cnt_o), 160'(0));
    check({tag, "_scnt"}, 160'(stall_cnt_o), 160'(0));
    check({tag, "_scnt_s"}, 160'(s_stall_cnt_o), 160'(0));
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1;
    rand_payload();
    repeat (3) begin
      @(negedge clk);
      rand_payload(); valid_i = 1'($urandom); stall_i = 1'($urandom); flush_i = 1'($urandom);
    end
    all_zero("reset");
    check_en = 1'b1;

    // Release and load a valid R-type.
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    r_type(5'd5);
    @(negedge clk);
    check("rtype_regwrite", 160'(RegWrite_o), 160'(1));
    check("rtype_rd", 160'(RDaddr_o), 160'(5));
    check("rtype_valid", 160'(valid_o), 160'(1));
    check("rtype_aluop", 160'(ALUOp_o), 160'(2));

    // Stall hold with changing inputs.
    r_type(5'd7);
    @(negedge clk);
    check("i1_rd", 160'(RDaddr_o), 160'(7));
    stall_i = 1'b1;
    repeat (3) begin
      rand_payload(); valid_i = 1'b1;
      @(negedge clk);
      check("stall_hold_rd", 160'(RDaddr_o), 160'(7));
    end
    check("stall_cnt_3", 160'(stall_cnt_o), 160'(3));

    // Deferred flush: pulse flush during stall, then release with a valid instruction.
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    @(negedge clk);
    stall_i = 1'b0;
    r_type(5'd11);
    @(negedge clk);
    check("defer_valid", 160'(valid_o), 160'(0));
    check("defer_regwrite", 160'(RegWrite_o), 160'(0));
    check("defer_bcnt", 160'(bubble_cnt_o), 160'(1));
    @(negedge clk);
    check("after_defer_valid", 160'(valid_o), 160'(1));
    check("after_defer_rd", 160'(RDaddr_o), 160'(11));

    // NoOp path: valid_i low gates a load-type bundle.
    rand_payload(); valid_i = 1'b0; MemRead_i = 1'b1; RDaddr_i = 5'd3;
    @(negedge clk);
    check("noop_memread", 160'(MemRead_o), 160'(0));
    check("noop_rd", 160'(RDaddr_o), 160'(0));
    check("noop_valid", 160'(valid_o), 160'(0));
    check("noop_bcnt", 160'(bubble_cnt_o), 160'(2));

    // Saturation of the 4-bit stall counter (5 stalls already counted).
    stall_i = 1'b1;
    repeat (20) begin rand_payload(); @(negedge clk); end
    check("sat_small", 160'(s_stall_cnt_o), 160'(15));
    check("sat_wide", 160'(stall_cnt_o), 160'(25));
    repeat (2) @(negedge clk);
    check("sat_small_hold", 160'(s_stall_cnt_o), 160'(15));

    // Async reset mid-stall with a pending flush.
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 all_zero("async");
    @(negedge clk);
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    r_type(5'd9);
    @(negedge clk);
    check("post_reset_valid", 160'(valid_o), 160'(1));
    check("post_reset_rd", 160'(RDaddr_o), 160'(9));

    // Randomized traffic; the compare process checks every cycle.
    repeat (600) begin
      rand_payload();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
